// File: rtl/conversor_leituras_mapa_if.sv
// Sensor/odometry inputs and mapper-facing outputs of conversor_leituras_mapa.
// leiturasDescartadas exists only when CONVERSOR_DESCARTES_EN is defined.
interface conversor_leituras_mapa_if #(
    parameter int tamanhoDistancia = 8,
    parameter int LarguraLeitura   = 16
);
    logic                        leituraValida;
    logic [LarguraLeitura-1:0]   distanciaDireitaCm;
    logic [LarguraLeitura-1:0]   distanciaEsquerdaCm;
    logic                        direcaoCarrinho;
    logic                        pulsoAvanco;
    logic                        sentidoAvanco;
    logic                        operacaoFinalizada;
    logic [tamanhoDistancia-1:0] posicaoAtualnoEixoX;
    logic [tamanhoDistancia-1:0] posicaoAtualnoEixoY;
    logic                        direcaoAtual;
    logic [tamanhoDistancia-1:0] distanciaDireita;
    logic [tamanhoDistancia-1:0] distanciaEsquerda;
    logic                        novoDado;
    logic                        ocupado;
`ifdef CONVERSOR_DESCARTES_EN
    logic [7:0]                  leiturasDescartadas;
`endif

    modport master (
`ifdef CONVERSOR_DESCARTES_EN
        input  leiturasDescartadas,
`endif
        output leituraValida, distanciaDireitaCm, distanciaEsquerdaCm, direcaoCarrinho,
        output pulsoAvanco, sentidoAvanco, operacaoFinalizada,
        input  posicaoAtualnoEixoX, posicaoAtualnoEixoY, direcaoAtual,
        input  distanciaDireita, distanciaEsquerda, novoDado, ocupado
    );

    modport slave (
`ifdef CONVERSOR_DESCARTES_EN
        output leiturasDescartadas,
`endif
        input  leituraValida, distanciaDireitaCm, distanciaEsquerdaCm, direcaoCarrinho,
        input  pulsoAvanco, sentidoAvanco, operacaoFinalizada,
        output posicaoAtualnoEixoX, posicaoAtualnoEixoY, direcaoAtual,
        output distanciaDireita, distanciaEsquerda, novoDado, ocupado
    );
endinterface

// File: rtl/conversor_leituras_mapa.sv
// Tracks cart grid position and converts cm readings to clamped cell counts for the mapper (CONVERSOR_DESCARTES_EN adds a drop counter).
// Latency: capture + up to TamanhoMalha-2 conversion cycles + one cycle to raise novoDado once the mapper is ready.
// Backpressure: holds outputs until the mapper's ready goes low then high; steps and one reading are buffered meanwhile.
module conversor_leituras_mapa #(
    parameter int TamanhoMalha     = 20,
    parameter int tamanhoDistancia = 8,
    parameter int LarguraLeitura   = 16,
    parameter int TamanhoCelulaCm  = 10,
    parameter int PosicaoInicialX  = 10,
    parameter int PosicaoInicialY  = 10
) (
    input logic                      clock,
    input logic                      reset,
    conversor_leituras_mapa_if.slave bus
);
    localparam logic [tamanhoDistancia-1:0] Um     = tamanhoDistancia'(1);
    localparam logic [tamanhoDistancia-1:0] PosMax = tamanhoDistancia'(TamanhoMalha - 2);
    localparam logic [tamanhoDistancia-1:0] IniX   = tamanhoDistancia'(PosicaoInicialX);
    localparam logic [tamanhoDistancia-1:0] IniY   = tamanhoDistancia'(PosicaoInicialY);
    localparam logic [LarguraLeitura-1:0]   Celula = LarguraLeitura'(TamanhoCelulaCm);

    typedef enum logic [1:0] {IDLE, CONVERTE, AGUARDA, OCUPADO} estado_t;

    estado_t                     estado_q;
    logic [tamanhoDistancia-1:0] pos_x_q, pos_y_q, pos_x_d, pos_y_d;
    logic signed [3:0]           pend_q, pend_d;
    logic                        buf_cheio_q;
    logic [LarguraLeitura-1:0]   buf_dir_q, buf_esq_q;
    logic [LarguraLeitura-1:0]   rem_dir_q, rem_esq_q;
    logic [tamanhoDistancia-1:0] quo_dir_q, quo_esq_q, lim_dir_q, lim_esq_q;
    logic [tamanhoDistancia-1:0] dist_dir_q, dist_esq_q;
    logic                        dir_atual_q, novo_q, ocupado_q, viu_baixo_q;

    logic                        step_vld, step_inc, inicia, adv_dir, adv_esq;
    logic [tamanhoDistancia-1:0] p_eixo;
    logic [LarguraLeitura-1:0]   raw_dir, raw_esq;

    // Pending steps drain first; a direct pulse only acts in IDLE with nothing pending.
    always_comb begin
        step_vld = 1'b0;
        step_inc = 1'b0;
        if (estado_q == IDLE) begin
            if (pend_q != 4'sd0) begin
                step_vld = 1'b1;
                step_inc = ~pend_q[3];
            end else if (bus.pulsoAvanco) begin
                step_vld = 1'b1;
                step_inc = bus.sentidoAvanco;
            end
        end
    end

    always_comb begin
        pos_x_d = pos_x_q;
        pos_y_d = pos_y_q;
        if (step_vld) begin
            if (bus.direcaoCarrinho) begin
                if (step_inc && pos_x_q < PosMax)      pos_x_d = pos_x_q + Um;
                else if (!step_inc && pos_x_q > Um)    pos_x_d = pos_x_q - Um;
            end else begin
                if (step_inc && pos_y_q < PosMax)      pos_y_d = pos_y_q + Um;
                else if (!step_inc && pos_y_q > Um)    pos_y_d = pos_y_q - Um;
            end
        end
    end

    always_comb begin
        pend_d = pend_q;
        if (estado_q == IDLE && pend_q != 4'sd0)
            pend_d = pend_q[3] ? pend_q + 4'sd1 : pend_q - 4'sd1;
        if (bus.pulsoAvanco && !(estado_q == IDLE && pend_q == 4'sd0)) begin
            if (bus.sentidoAvanco && pend_d != 4'sd7)        pend_d = pend_d + 4'sd1;
            else if (!bus.sentidoAvanco && pend_d != -4'sd7) pend_d = pend_d - 4'sd1;
        end
    end

    // Limits use the post-step coordinate so the presented position and distances agree.
    always_comb begin
        inicia  = (estado_q == IDLE) && (pend_q == 4'sd0) && (buf_cheio_q || bus.leituraValida);
        raw_dir = buf_cheio_q ? buf_dir_q : bus.distanciaDireitaCm;
        raw_esq = buf_cheio_q ? buf_esq_q : bus.distanciaEsquerdaCm;
        p_eixo  = bus.direcaoCarrinho ? pos_x_d : pos_y_d;
        adv_dir = (rem_dir_q >= Celula) && (quo_dir_q < lim_dir_q);
        adv_esq = (rem_esq_q >= Celula) && (quo_esq_q < lim_esq_q);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q    <= IDLE;
            pos_x_q     <= IniX;
            pos_y_q     <= IniY;
            pend_q      <= 4'sd0;
            buf_cheio_q <= 1'b0;
            buf_dir_q   <= '0;
            buf_esq_q   <= '0;
            rem_dir_q   <= '0;
            rem_esq_q   <= '0;
            quo_dir_q   <= '0;
            quo_esq_q   <= '0;
            lim_dir_q   <= '0;
            lim_esq_q   <= '0;
            dist_dir_q  <= '0;
            dist_esq_q  <= '0;
            dir_atual_q <= 1'b0;
            novo_q      <= 1'b0;
            ocupado_q   <= 1'b0;
            viu_baixo_q <= 1'b0;
        end else begin
            novo_q  <= 1'b0;
            pend_q  <= pend_d;
            pos_x_q <= pos_x_d;
            pos_y_q <= pos_y_d;

            // A reading consumed directly in IDLE bypasses the buffer; otherwise newest wins.
            if (bus.leituraValida && (buf_cheio_q || !inicia)) begin
                buf_cheio_q <= 1'b1;
                buf_dir_q   <= bus.distanciaDireitaCm;
                buf_esq_q   <= bus.distanciaEsquerdaCm;
            end else if (inicia) begin
                buf_cheio_q <= 1'b0;
            end

            case (estado_q)
                IDLE: begin
                    if (inicia) begin
                        rem_dir_q   <= raw_dir;
                        rem_esq_q   <= raw_esq;
                        quo_dir_q   <= '0;
                        quo_esq_q   <= '0;
                        lim_dir_q   <= PosMax - p_eixo;
                        lim_esq_q   <= p_eixo - Um;
                        dir_atual_q <= bus.direcaoCarrinho;
                        ocupado_q   <= 1'b1;
                        estado_q    <= CONVERTE;
                    end
                end
                CONVERTE: begin
                    if (adv_dir) begin
                        rem_dir_q <= rem_dir_q - Celula;
                        quo_dir_q <= quo_dir_q + Um;
                    end
                    if (adv_esq) begin
                        rem_esq_q <= rem_esq_q - Celula;
                        quo_esq_q <= quo_esq_q + Um;
                    end
                    if (!adv_dir && !adv_esq) begin
                        dist_dir_q <= quo_dir_q;
                        dist_esq_q <= quo_esq_q;
                        estado_q   <= AGUARDA;
                    end
                end
                AGUARDA: begin
                    if (bus.operacaoFinalizada) begin
                        novo_q      <= 1'b1;
                        viu_baixo_q <= 1'b0;
                        estado_q    <= OCUPADO;
                    end
                end
                OCUPADO: begin
                    if (!bus.operacaoFinalizada) begin
                        viu_baixo_q <= 1'b1;
                    end else if (viu_baixo_q) begin
                        ocupado_q <= 1'b0;
                        estado_q  <= IDLE;
                    end
                end
                default: estado_q <= IDLE;
            endcase
        end
    end

    assign bus.posicaoAtualnoEixoX = pos_x_q;
    assign bus.posicaoAtualnoEixoY = pos_y_q;
    assign bus.direcaoAtual        = dir_atual_q;
    assign bus.distanciaDireita    = dist_dir_q;
    assign bus.distanciaEsquerda   = dist_esq_q;
    assign bus.novoDado            = novo_q;
    assign bus.ocupado             = ocupado_q;

`ifdef CONVERSOR_DESCARTES_EN
    logic [7:0] descartes_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            descartes_q <= '0;
        end else if (bus.leituraValida && buf_cheio_q && !inicia && descartes_q != 8'hFF) begin
            descartes_q <= descartes_q + 8'd1;
        end
    end

    assign bus.leiturasDescartadas = descartes_q;
`else
    // Overwriting a full buffer is silent in this build.
`endif
endmodule

// File: tb/tb_conversor_leituras_mapa.sv
// Bench for conversor_leituras_mapa: table vectors, hand-written corner sequences, random traffic vs a cell-arithmetic model.
module tb_conversor_leituras_mapa;
    localparam int N    = 20;
    localparam int CELL = 10;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    conversor_leituras_mapa_if #(.tamanhoDistancia(8), .LarguraLeitura(16)) bus ();

    conversor_leituras_mapa #(
        .TamanhoMalha(N), .tamanhoDistancia(8), .LarguraLeitura(16),
        .TamanhoCelulaCm(CELL), .PosicaoInicialX(10), .PosicaoInicialY(10)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    int n_vec = 0;
    int n_err = 0;
    int mx = 10;
    int my = 10;

    typedef struct {
        logic eixo;
        int   pos;
        int   cmd;
        int   cme;
        int   edir;
        int   eesq;
        int   elat;
    } vec_t;

    vec_t tab [7];

    task automatic check(input string nome, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", nome, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic int sat(input int v);
        return (v < 1) ? 1 : ((v > N - 2) ? N - 2 : v);
    endfunction

    function automatic int minimo(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic pulse(input logic eixo, input logic inc);
        bus.direcaoCarrinho = eixo;
        bus.sentidoAvanco   = inc;
        bus.pulsoAvanco     = 1'b1;
        tick();
        bus.pulsoAvanco     = 1'b0;
        if (eixo) mx = sat(mx + (inc ? 1 : -1));
        else      my = sat(my + (inc ? 1 : -1));
    endtask

    task automatic move_to(input logic eixo, input int alvo);
        for (int k = 0; k < 40; k++) begin
            if ((eixo ? mx : my) != alvo) pulse(eixo, (eixo ? mx : my) < alvo);
        end
    endtask

    task automatic check_pos(input string nome);
        check({nome, "_x"}, int'(bus.posicaoAtualnoEixoX), mx);
        check({nome, "_y"}, int'(bus.posicaoAtualnoEixoY), my);
    endtask

    task automatic check_reset_vals(input string nome);
        check({nome, "_x"}, int'(bus.posicaoAtualnoEixoX), 10);
        check({nome, "_y"}, int'(bus.posicaoAtualnoEixoY), 10);
        check({nome, "_dirAtual"}, int'(bus.direcaoAtual), 0);
        check({nome, "_dDir"}, int'(bus.distanciaDireita), 0);
        check({nome, "_dEsq"}, int'(bus.distanciaEsquerda), 0);
        check({nome, "_novo"}, int'(bus.novoDado), 0);
        check({nome, "_ocupado"}, int'(bus.ocupado), 0);
`ifdef CONVERSOR_DESCARTES_EN
        check({nome, "_descartes"}, int'(bus.leiturasDescartadas), 0);
`endif
    endtask

    task automatic wait_novo(input string nome, output int lat);
        lat = 0;
        for (int c = 1; c <= 60; c++) begin
            if (lat == 0) begin
                tick();
                if (bus.novoDado) lat = c;
            end
        end
        if (lat == 0) check({nome, "_novo_timeout"}, 0, 1);
    endtask

    task automatic leitura(input logic eixo, input int cmd, input int cme);
        bus.direcaoCarrinho     = eixo;
        bus.distanciaDireitaCm  = 16'(cmd);
        bus.distanciaEsquerdaCm = 16'(cme);
        bus.leituraValida       = 1'b1;
        tick();
        bus.leituraValida       = 1'b0;
    endtask

    // Mapper ready must go low and come back before the block is free again.
    task automatic liberar(input string nome);
        tick();
        check({nome, "_novo_1ciclo"}, int'(bus.novoDado), 0);
        check({nome, "_ocupado_sem_baixa"}, int'(bus.ocupado), 1);
        bus.operacaoFinalizada = 1'b0;
        tick();
        check({nome, "_ocupado_baixa"}, int'(bus.ocupado), 1);
        bus.operacaoFinalizada = 1'b1;
        tick();
        check({nome, "_ocupado_fim"}, int'(bus.ocupado), 0);
    endtask

    task automatic transacao(input logic eixo, input int cmd, input int cme,
                             input int edir, input int eesq, input int elat, input string nome);
        int lat;
        leitura(eixo, cmd, cme);
        check({nome, "_ocupado_ini"}, int'(bus.ocupado), 1);
        wait_novo(nome, lat);
        if (elat >= 0) check({nome, "_latencia"}, lat, elat);
        check({nome, "_dDir"}, int'(bus.distanciaDireita), edir);
        check({nome, "_dEsq"}, int'(bus.distanciaEsquerda), eesq);
        check({nome, "_dirAtual"}, int'(bus.direcaoAtual), int'(eixo));
        check_pos(nome);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, p, edir, eesq, net, nq;
        logic eixo, inc, viu_novo, viu_ocup;

        bus.leituraValida       = 1'b0;
        bus.distanciaDireitaCm  = '0;
        bus.distanciaEsquerdaCm = '0;
        bus.direcaoCarrinho     = 1'b1;
        bus.pulsoAvanco         = 1'b0;
        bus.sentidoAvanco       = 1'b0;
        bus.operacaoFinalizada  = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        check_reset_vals("reset");

        // {axis, coordinate, dir cm, esq cm, dDir, dEsq, ticks to novoDado}
        tab[0] = '{1'b1, 10,    55,  23,  5,  2,  7};
        tab[1] = '{1'b1, 16,   200, 200,  2, 15, 17};
        tab[2] = '{1'b0, 10,     5,   9,  0,  0,  2};
        tab[3] = '{1'b1,  1,   300, 300, 17,  0, 19};
        tab[4] = '{1'b0, 18,   100, 100,  0, 10, 12};
        tab[5] = '{1'b1,  5,    10,  40,  1,  4,  6};
        tab[6] = '{1'b0,  3, 65535,  19, 15,  1, 17};
        for (int i = 0; i < 7; i++) begin
            move_to(tab[i].eixo, tab[i].pos);
            transacao(tab[i].eixo, tab[i].cmd, tab[i].cme, tab[i].edir, tab[i].eesq,
                      tab[i].elat, $sformatf("tab%0d", i));
            liberar($sformatf("tab%0d", i));
        end

        // Steps during OCUPADO are deferred, then drained before the buffered reading.
        move_to(1'b0, 10);
        transacao(1'b0, 30, 40, 3, 4, 6, "pend");
        bus.operacaoFinalizada  = 1'b0;
        bus.distanciaDireitaCm  = 16'd50;
        bus.distanciaEsquerdaCm = 16'd60;
        bus.leituraValida       = 1'b1;
        for (int k = 0; k < 3; k++) begin
            bus.direcaoCarrinho = 1'b0;
            bus.sentidoAvanco   = 1'b0;
            bus.pulsoAvanco     = 1'b1;
            tick();
            bus.leituraValida   = 1'b0;
            check($sformatf("pend_hold%0d_y", k), int'(bus.posicaoAtualnoEixoY), 10);
        end
        bus.pulsoAvanco        = 1'b0;
        bus.operacaoFinalizada = 1'b1;
        tick();
        check("pend_idle_ocupado", int'(bus.ocupado), 0);
        check("pend_idle_y", int'(bus.posicaoAtualnoEixoY), 10);
        for (int k = 9; k >= 7; k--) begin
            tick();
            check($sformatf("pend_step_y%0d", k), int'(bus.posicaoAtualnoEixoY), k);
            check($sformatf("pend_step_ocup%0d", k), int'(bus.ocupado), 0);
        end
        my = 7;
        tick();
        check("pend_conv_ocupado", int'(bus.ocupado), 1);
        wait_novo("pend2", lat);
        check("pend2_latencia", lat, 8);
        check("pend2_dDir", int'(bus.distanciaDireita), 5);
        check("pend2_dEsq", int'(bus.distanciaEsquerda), 6);
        check_pos("pend2");
        liberar("pend2");

        // Newest of three buffered readings wins.
        move_to(1'b1, 10);
        transacao(1'b1, 100, 100, 8, 9, 11, "buf");
        bus.operacaoFinalizada = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            bus.distanciaDireitaCm  = 16'(10 * k);
            bus.distanciaEsquerdaCm = 16'(10 * k);
            bus.leituraValida       = 1'b1;
            tick();
        end
        bus.leituraValida      = 1'b0;
        bus.operacaoFinalizada = 1'b1;
        tick();
        wait_novo("buf2", lat);
        check("buf2_latencia", lat, 6);
        check("buf2_dDir", int'(bus.distanciaDireita), 3);
        check("buf2_dEsq", int'(bus.distanciaEsquerda), 3);
`ifdef CONVERSOR_DESCARTES_EN
        check("buf2_descartes", int'(bus.leiturasDescartadas), 2);
`endif
        liberar("buf2");

        // Position saturation at both ends of the legal range.
        move_to(1'b1, 1);
        for (int k = 0; k < 8; k++) pulse(1'b1, 1'b0);
        check("sat_min_x", int'(bus.posicaoAtualnoEixoX), 1);
        move_to(1'b1, 18);
        pulse(1'b1, 1'b1);
        check("sat_max_x", int'(bus.posicaoAtualnoEixoX), 18);

        // Reset mid-conversion drops the buffer and pending steps.
        move_to(1'b1, 10);
        leitura(1'b1, 200, 200);
        bus.distanciaDireitaCm  = 16'd150;
        bus.distanciaEsquerdaCm = 16'd150;
        bus.leituraValida       = 1'b1;
        bus.pulsoAvanco         = 1'b1;
        bus.sentidoAvanco       = 1'b1;
        tick();
        bus.leituraValida       = 1'b0;
        bus.pulsoAvanco         = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        mx = 10;
        my = 10;
        check_reset_vals("rst_conv");
        viu_novo = 1'b0;
        viu_ocup = 1'b0;
        for (int k = 0; k < 30; k++) begin
            tick();
            if (bus.novoDado) viu_novo = 1'b1;
            if (bus.ocupado)  viu_ocup = 1'b1;
        end
        check("rst_conv_sem_novo", int'(viu_novo), 0);
        check("rst_conv_buffer_vazio", int'(viu_ocup), 0);
        check_pos("rst_conv_pos");

        // Random traffic against the cell-arithmetic model.
        for (int it = 0; it < 40; it++) begin
            eixo = 1'($urandom_range(0, 1));
            for (int j = 0; j < int'($urandom_range(0, 5)); j++) pulse(eixo, 1'($urandom_range(0, 1)));
            p    = eixo ? mx : my;
            edir = minimo(int'($urandom_range(0, 220)), 100000);
            eesq = minimo(int'($urandom_range(0, 220)), 100000);
            transacao(eixo, edir, eesq, minimo(edir / CELL, N - 2 - p), minimo(eesq / CELL, p - 1),
                      -1, $sformatf("rnd%0d", it));
            bus.operacaoFinalizada = 1'b0;
            tick();
            net = 0;
            nq  = int'($urandom_range(0, 3));
            for (int j = 0; j < nq; j++) begin
                inc = 1'($urandom_range(0, 1));
                bus.sentidoAvanco = inc;
                bus.pulsoAvanco   = 1'b1;
                tick();
                net += inc ? 1 : -1;
            end
            bus.pulsoAvanco        = 1'b0;
            bus.operacaoFinalizada = 1'b1;
            for (int k = 0; k < 5; k++) if (bus.ocupado) tick();
            check($sformatf("rnd%0d_libera", it), int'(bus.ocupado), 0);
            repeat (8) tick();
            for (int k = 0; k < (net < 0 ? -net : net); k++) begin
                if (eixo) mx = sat(mx + (net > 0 ? 1 : -1));
                else      my = sat(my + (net > 0 ? 1 : -1));
            end
            check_pos($sformatf("rnd%0d_pend", it));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/conversor_leituras_mapa.md
Name: conversor_leituras_mapa

Overview:
- Upstream feeder for the occupancy-grid mapper (`mapas`).
- Tracks the cart's grid position from encoder step pulses.
- Converts raw right/left ultrasonic distances (cm) into whole grid cells, clamped so every mapper write stays inside the grid.
- Presents one update at a time over the mapper's `novoDado`/`operacaoFinalizada` handshake, and holds position and distances stable while the mapper marks cells.

Parameters:
- TamanhoMalha, 20, grid side in cells; must match the mapper.
- tamanhoDistancia, 8, width in bits of grid coordinates and cell distances.
- LarguraLeitura, 16, width of the raw sensor distance in cm.
- TamanhoCelulaCm, 10, cell edge in cm; must be ≥1.
- PosicaoInicialX, 10, reset X coordinate; legal range 1..TamanhoMalha-2.
- PosicaoInicialY, 10, reset Y coordinate; legal range 1..TamanhoMalha-2.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- leituraValida  in  1  one-cycle strobe: a new sensor pair is present.
- distanciaDireitaCm  in  LarguraLeitura  raw right distance.
- distanciaEsquerdaCm  in  LarguraLeitura  raw left distance.
- direcaoCarrinho  in  1  cart heading axis: 1 horizontal (X), 0 vertical (Y).
- pulsoAvanco  in  1  one-cycle strobe: the cart advanced one cell.
- sentidoAvanco  in  1  step direction: 1 increment, 0 decrement.
- operacaoFinalizada  in  1  mapper ready.
- posicaoAtualnoEixoX  out  tamanhoDistancia  to mapper.
- posicaoAtualnoEixoY  out  tamanhoDistancia  to mapper.
- direcaoAtual  out  1  axis latched with the reading.
- distanciaDireita  out  tamanhoDistancia  cells.
- distanciaEsquerda  out  tamanhoDistancia  cells.
- novoDado  out  1  one-cycle request to the mapper.
- ocupado  out  1  high whenever state is not IDLE.

Behaviour:
- Reset values:
  - Position = (PosicaoInicialX, PosicaoInicialY).
  - direcaoAtual = 0; both distances = 0; novoDado = 0; ocupado = 0.
  - State = IDLE; pending-step counter = 0; reading buffer empty.
  - Reset mid-operation abandons everything, including the buffer and pending steps.
- Position range:
  - Coordinates are confined to 1..TamanhoMalha-2; border rows and columns are never occupied by the cart.
  - A step that would leave this range is ignored (saturation).
  - A step changes X when direcaoCarrinho=1 and Y when direcaoCarrinho=0.
- Step handling:
  - Position outputs change only in IDLE.
  - A pulsoAvanco in any other state goes to a signed pending counter: +1 or -1, saturating at ±7.
  - In IDLE, a nonzero pending counter is applied one step per cycle, using the current direcaoCarrinho. This takes priority over starting a conversion.
  - A pulsoAvanco arriving in IDLE while pending=0 updates position on the next edge.
- Reading buffer:
  - One entry.
  - A leituraValida outside IDLE (or in IDLE while pending≠0) writes the buffer. If the buffer is already full, the old entry is overwritten (newest wins).
- States:
  - IDLE:
    - Requires pending=0.
    - If the buffer is full, or leituraValida=1, capture the raw pair (buffer has precedence; a simultaneous leituraValida then refills the buffer) and latch direcaoAtual ← direcaoCarrinho.
    - Clear both quotients, compute the limits, then go to CONVERTE.
    - Limits, on the heading axis coordinate p:
      - limDir = TamanhoMalha-2-p.
      - limEsq = p-1.
  - CONVERTE:
    - Each cycle, for each side independently: if remainder ≥ TamanhoCelulaCm and quotient < limit, then remainder -= TamanhoCelulaCm and quotient += 1.
    - When neither side can advance, drive distanciaDireita/distanciaEsquerda with the quotients and go to AGUARDA.
    - Latency is ≤ max(limDir, limEsq)+1 cycles; worst case TamanhoMalha-2.
    - The result is floor(cm/TamanhoCelulaCm), clamped to the limit.
  - AGUARDA: when operacaoFinalizada=1, assert novoDado for exactly one cycle and go to OCUPADO.
  - OCUPADO:
    - First wait for operacaoFinalizada=0, then wait for operacaoFinalizada=1, then go to IDLE.
    - Outputs are held constant throughout.
- Clamping guarantee: p+dDir+1 ≤ TamanhoMalha-1 and p-dEsq-1 ≥ 0 always hold.
- Zero distance: a raw value below TamanhoCelulaCm gives 0 cells.
- Width rules:
  - All subtraction is unsigned on LarguraLeitura bits.
  - Quotients are tamanhoDistancia bits and never exceed TamanhoMalha-3.

Optional Feature:
- Macro: CONVERSOR_DESCARTES_EN.
- Defined:
  - Adds output leiturasDescartadas [7:0].
  - It increments, saturating at 255, each time a full buffer is overwritten.
  - Reset value is 0.
- Undefined: the port and counter do not exist; overwrite behaviour is unchanged.

Test Plan:
1. Defaults, heading X, pos (10,10), dir=55cm, esq=23cm, mapper ready → 5 and 2 on the distances, novoDado one cycle, ocupado until the mapper's low-then-high.
2. Pos X=16, direcaoCarrinho=1, dir=200cm, esq=200cm → distanciaDireita=2 (clamped), distanciaEsquerda=15 (clamped); CONVERTE lasts 16 cycles.
3. 3 decrement pulses during OCUPADO with heading Y, Y=10 → Y unchanged until IDLE, then 9, 8, 7 on successive cycles, and only then the buffered reading converts.
4. Three leituraValida while OCUPADO (values 10/10, 20/20, 30/30 cm) → next update uses 3/3; with CONVERSOR_DESCARTES_EN, leiturasDescartadas=2.
5. X=1, 8 decrement pulses → X stays 1; X=18, increment → stays 18.
6. Reset asserted in CONVERTE → next cycle all outputs equal reset values, novoDado never pulses, buffer empty.
